// File: rtl/cnn_mem_arbiter.sv
// cnn_mem_arbiter
// Shares the single-ported 256x16 cnn_mem RAM between the HPS Avalon-MM host
// path and the CNN compute engine. One command is in flight at a time; the
// FSM walks IDLE -> ISSUE -> (CAPTURE ->) RESP and absorbs the RAM's one-cycle
// registered read latency before handing data back to the winner.
//
// Optional feature: define CNN_ARB_HOST_PRIORITY_EN for fixed host priority
// (host wins every tie, engine may starve). Default build is round-robin.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   h_chipselect/h_read/h_write    host Avalon-MM command (read+write = write)
//   h_address, h_writedata         host word address / write data
//   h_readdata, h_waitrequest      host read data / stall (combinational)
//   e_req, e_we, e_addr, e_wdata   engine level request and command
//   e_gnt, e_rvalid, e_rdata       engine accept pulse, read-data pulse/data
//   m_chipselect/m_read/m_write    RAM strobes (only high in ISSUE)
//   m_address, m_writedata         RAM address (zero-extended) / write data
//   m_val_out                      RAM registered read data
//   dbg_state                      current FSM state (0 IDLE, 1 ISSUE,
//                                  2 CAPTURE, 3 RESP)
//
// Handshake: the engine holds e_req and its command until the cycle e_gnt is
// high; the host holds its command until h_waitrequest is low. Both may
// present a new command in the following cycle.
module cnn_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_chipselect,
    input  logic              h_read,
    input  logic              h_write,
    input  logic [ADDR_W-1:0] h_address,
    input  logic [DATA_W-1:0] h_writedata,
    output logic [DATA_W-1:0] h_readdata,
    output logic              h_waitrequest,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic              m_chipselect,
    output logic              m_read,
    output logic              m_write,
    output logic [15:0]       m_address,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_val_out,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic WIN_HOST = 1'b0;
    localparam logic WIN_ENG  = 1'b1;

    state_t            state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_winner_q, last_winner_d;
    logic              cmd_we_q, cmd_we_d;
    logic              m_chipselect_q, m_chipselect_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [15:0]       m_address_q, m_address_d;
    logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
    logic              e_gnt_q, e_gnt_d;
    logic              e_rvalid_q, e_rvalid_d;
    logic [DATA_W-1:0] e_rdata_q, e_rdata_d;
    logic [DATA_W-1:0] h_readdata_q, h_readdata_d;

    logic hreq;
    logic host_wins;

    assign hreq = h_chipselect & (h_read | h_write);

    always_comb begin
        if (hreq && e_req) begin
`ifdef CNN_ARB_HOST_PRIORITY_EN
            host_wins = 1'b1;
`else
            // Tie goes to whoever did not win last time.
            host_wins = (last_winner_q == WIN_ENG);
`endif
        end else begin
            host_wins = hreq;
        end
    end

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        last_winner_d  = last_winner_q;
        cmd_we_d       = cmd_we_q;
        m_chipselect_d = 1'b0;
        m_read_d       = 1'b0;
        m_write_d      = 1'b0;
        m_address_d    = '0;
        m_writedata_d  = '0;
        e_gnt_d        = 1'b0;
        e_rvalid_d     = 1'b0;
        e_rdata_d      = e_rdata_q;
        h_readdata_d   = h_readdata_q;

        case (state_q)
            S_IDLE: begin
                if (hreq || e_req) begin
                    // The RAM strobes are loaded here so they appear
                    // registered during ISSUE.
                    winner_d       = host_wins ? WIN_HOST : WIN_ENG;
                    last_winner_d  = winner_d;
                    cmd_we_d       = host_wins ? h_write : e_we;
                    m_chipselect_d = 1'b1;
                    m_write_d      = cmd_we_d;
                    m_read_d       = ~cmd_we_d;
                    m_address_d    = 16'(host_wins ? h_address : e_addr);
                    m_writedata_d  = host_wins ? h_writedata : e_wdata;
                    e_gnt_d        = ~host_wins;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = cmd_we_q ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: begin
                // m_val_out now holds the word addressed during ISSUE.
                if (winner_q == WIN_HOST) begin
                    h_readdata_d = m_val_out;
                end else begin
                    e_rdata_d  = m_val_out;
                    e_rvalid_d = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            winner_q       <= WIN_HOST;
            last_winner_q  <= WIN_ENG;
            cmd_we_q       <= 1'b0;
            m_chipselect_q <= 1'b0;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            e_gnt_q        <= 1'b0;
            e_rvalid_q     <= 1'b0;
            e_rdata_q      <= '0;
            h_readdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            last_winner_q  <= last_winner_d;
            cmd_we_q       <= cmd_we_d;
            m_chipselect_q <= m_chipselect_d;
            m_read_q       <= m_read_d;
            m_write_q      <= m_write_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            e_gnt_q        <= e_gnt_d;
            e_rvalid_q     <= e_rvalid_d;
            e_rdata_q      <= e_rdata_d;
            h_readdata_q   <= h_readdata_d;
        end
    end

    // Only the host stall is combinational: it must be high in the very cycle
    // a request appears, including while reset is asserted.
    assign h_waitrequest = hreq & ~((state_q == S_RESP) && (winner_q == WIN_HOST));

    assign m_chipselect = m_chipselect_q;
    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign e_gnt        = e_gnt_q;
    assign e_rvalid     = e_rvalid_q;
    assign e_rdata      = e_rdata_q;
    assign h_readdata   = h_readdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
module tb_cnn_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        h_chipselect, h_read, h_write;
    logic [7:0]  h_address;
    logic [15:0] h_writedata, h_readdata;
    logic        h_waitrequest;
    logic        e_req, e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata, e_rdata;
    logic        e_gnt, e_rvalid;
    logic        m_chipselect, m_read, m_write;
    logic [15:0] m_address, m_writedata, m_val_out;
    logic [1:0]  dbg_state;

    cnn_mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .h_chipselect(h_chipselect), .h_read(h_read), .h_write(h_write),
        .h_address(h_address), .h_writedata(h_writedata),
        .h_readdata(h_readdata), .h_waitrequest(h_waitrequest),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_writedata(m_writedata),
        .m_val_out(m_val_out), .dbg_state(dbg_state)
    );

    // ---------------- RAM environment (registered read) ----------------
    logic        mem_clr;
    logic [15:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= '0;
            m_val_out <= '0;
        end else if (m_chipselect) begin
            if (m_write) env_mem[m_address[7:0]] <= m_writedata;
            else if (m_read) m_val_out <= env_mem[m_address[7:0]];
        end
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected per-cycle output picture, scheduled ahead by the model.
    typedef struct {
        logic        cs, rd, wr, gnt, rvalid, hresp, hupd, eupd;
        logic [15:0] addr, wdata, rdata;
    } slot_t;

    function automatic slot_t blank();
        slot_t s;
        s.cs = 0; s.rd = 0; s.wr = 0; s.gnt = 0; s.rvalid = 0;
        s.hresp = 0; s.hupd = 0; s.eupd = 0;
        s.addr = '0; s.wdata = '0; s.rdata = '0;
        return s;
    endfunction

    slot_t       sched [8];
    slot_t       cur;
    logic [15:0] ref_mem [256];
    int          next_free;
    logic        last_eng;
    logic [15:0] exp_h_rdata, exp_e_rdata;
    logic        mon_en;
    logic        hreq_v, eng, we;
    logic [7:0]  a;
    logic [15:0] d;

    logic [0:0]  grant_q[$];
    logic [0:0]  exp_q[$];

    // events observed for the directed literal checks
    logic        h_done_flag, e_gnt_flag;
    int          h_done_cyc, e_gnt_cyc, e_rv_cyc, last_mwr_cyc;
    logic [15:0] h_done_data, e_rv_data, last_mwr_addr;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) sched[i] = blank();
        next_free   = 0;
        last_eng    = 1'b1;
        exp_h_rdata = '0;
        exp_e_rdata = '0;
        h_done_flag = 1'b0;
        e_gnt_flag  = 1'b0;
    endtask

    // Compare + reference model: one command at a time, a write occupies
    // 3 cycles and a read 4, results appear at fixed offsets from the
    // arbitration cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_clr) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            if (!reset && mon_en) begin
                cur = sched[cyc % 8];
                sched[cyc % 8] = blank();
                if (cur.hupd) exp_h_rdata = cur.rdata;
                if (cur.eupd) exp_e_rdata = cur.rdata;
                hreq_v = h_chipselect & (h_read | h_write);

                chk("m_chipselect", m_chipselect, cur.cs);
                chk("m_read", m_read, cur.rd);
                chk("m_write", m_write, cur.wr);
                if (cur.cs) begin
                    chk("m_address", m_address, cur.addr);
                    chk("m_writedata", m_writedata, cur.wdata);
                end
                chk("e_gnt", e_gnt, cur.gnt);
                chk("e_rvalid", e_rvalid, cur.rvalid);
                chk("e_rdata", e_rdata, exp_e_rdata);
                chk("h_readdata", h_readdata, exp_h_rdata);
                chk("h_waitrequest", h_waitrequest, hreq_v & ~cur.hresp);

                if (hreq_v && !h_waitrequest) begin
                    h_done_flag = 1'b1; h_done_cyc = cyc; h_done_data = h_readdata;
                end
                if (e_gnt) begin e_gnt_flag = 1'b1; e_gnt_cyc = cyc; end
                if (e_rvalid) begin e_rv_cyc = cyc; e_rv_data = e_rdata; end
                if (m_write) begin last_mwr_cyc = cyc; last_mwr_addr = m_address; end
                if (m_chipselect) grant_q.push_back(e_gnt);

                if (cyc >= next_free && (hreq_v || e_req)) begin
                    if (hreq_v && e_req) begin
`ifdef CNN_ARB_HOST_PRIORITY_EN
                        eng = 1'b0;
`else
                        eng = ~last_eng;
`endif
                    end else begin
                        eng = ~hreq_v;
                    end
                    last_eng = eng;
                    we = eng ? e_we : h_write;
                    a  = eng ? e_addr : h_address;
                    d  = eng ? e_wdata : h_writedata;
                    sched[(cyc + 1) % 8].cs    = 1'b1;
                    sched[(cyc + 1) % 8].wr    = we;
                    sched[(cyc + 1) % 8].rd    = ~we;
                    sched[(cyc + 1) % 8].addr  = {8'h00, a};
                    sched[(cyc + 1) % 8].wdata = d;
                    sched[(cyc + 1) % 8].gnt   = eng;
                    if (we) begin
                        ref_mem[a] = d;
                        sched[(cyc + 2) % 8].hresp = ~eng;
                        next_free = cyc + 3;
                    end else begin
                        sched[(cyc + 3) % 8].hresp  = ~eng;
                        sched[(cyc + 3) % 8].rvalid = eng;
                        sched[(cyc + 3) % 8].hupd   = ~eng;
                        sched[(cyc + 3) % 8].eupd   = eng;
                        sched[(cyc + 3) % 8].rdata  = ref_mem[a];
                        next_free = cyc + 4;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- drivers ----------------
    typedef struct { logic rd; logic wr; logic [7:0] addr; logic [15:0] data; } hcmd_t;
    typedef struct { logic we; logic [7:0] addr; logic [15:0] data; } ecmd_t;
    hcmd_t h_q[$];
    ecmd_t e_q[$];
    logic  h_busy, e_busy;
    int    h_rate, e_rate;
    int    h_start_cyc, e_start_cyc;

    task automatic push_h(input logic rd, input logic wr, input logic [7:0] ad, input logic [15:0] dt);
        hcmd_t c;
        c.rd = rd; c.wr = wr; c.addr = ad; c.data = dt;
        h_q.push_back(c);
    endtask

    task automatic push_e(input logic w, input logic [7:0] ad, input logic [15:0] dt);
        ecmd_t c;
        c.we = w; c.addr = ad; c.data = dt;
        e_q.push_back(c);
    endtask

    task automatic drive_inputs();
        hcmd_t hc;
        ecmd_t ec;
        if (h_done_flag) begin h_busy = 1'b0; h_done_flag = 1'b0; end
        if (e_gnt_flag)  begin e_busy = 1'b0; e_gnt_flag  = 1'b0; end
        if (!h_busy) begin
            if (h_q.size() > 0 && $urandom_range(1, 100) <= h_rate) begin
                hc = h_q.pop_front();
                h_chipselect = 1'b1; h_read = hc.rd; h_write = hc.wr;
                h_address = hc.addr; h_writedata = hc.data;
                h_busy = 1'b1; h_start_cyc = cyc;
            end else begin
                h_chipselect = 1'b0; h_read = 1'($urandom_range(0, 1)); h_write = 1'b0;
                h_address = 8'($urandom); h_writedata = 16'($urandom);
            end
        end
        if (!e_busy) begin
            if (e_q.size() > 0 && $urandom_range(1, 100) <= e_rate) begin
                ec = e_q.pop_front();
                e_req = 1'b1; e_we = ec.we; e_addr = ec.addr; e_wdata = ec.data;
                e_busy = 1'b1; e_start_cyc = cyc;
            end else begin
                e_req = 1'b0; e_we = 1'($urandom_range(0, 1));
                e_addr = 8'($urandom); e_wdata = 16'($urandom);
            end
        end
    endtask

    task automatic run_cycle();
        @(posedge clk); #1;
        drive_inputs();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((h_busy || e_busy || h_q.size() > 0 || e_q.size() > 0) && n < budget) begin
            run_cycle();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
        repeat (5) run_cycle();
    endtask

    task automatic idle_inputs();
        h_chipselect = 0; h_read = 0; h_write = 0; h_address = '0; h_writedata = '0;
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        h_busy = 0; e_busy = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        drive_inputs();
    endtask

    // ---------------- test sequence ----------------
    int rel_cyc;

    initial begin
        reset = 1'b1; mem_clr = 1'b1; mon_en = 1'b0;
        idle_inputs();
        h_rate = 100; e_rate = 100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        h_chipselect = 1'b1; h_read = 1'b1;
        #1;
        chk("rst_state", dbg_state, 2'd0);
        chk("rst_mstrobes", {m_chipselect, m_read, m_write}, 3'b000);
        chk("rst_e_pulses", {e_gnt, e_rvalid}, 2'b00);
        chk("rst_e_rdata", e_rdata, 16'h0000);
        chk("rst_h_readdata", h_readdata, 16'h0000);
        chk("rst_waitrequest", h_waitrequest, 1'b1);
        h_chipselect = 1'b0; h_read = 1'b0;
        mem_clr = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive_inputs();

        // host write then read back
        push_h(1'b0, 1'b1, 8'h05, 16'h1234);
        wait_idle(50);
        chk("hw_resp_latency", h_done_cyc - h_start_cyc, 2);
        chk("hw_mwrite_cycle", last_mwr_cyc - h_start_cyc, 1);
        chk("hw_maddr", last_mwr_addr, 16'h0005);
        push_h(1'b1, 1'b0, 8'h05, 16'h0000);
        wait_idle(50);
        chk("hr_resp_latency", h_done_cyc - h_start_cyc, 3);
        chk("hr_data", h_done_data, 16'h1234);

        // engine write then read back
        push_e(1'b1, 8'h10, 16'hBEEF);
        wait_idle(50);
        chk("ew_gnt_latency", e_gnt_cyc - e_start_cyc, 1);
        push_e(1'b0, 8'h10, 16'h0000);
        wait_idle(50);
        chk("er_gnt_latency", e_gnt_cyc - e_start_cyc, 1);
        chk("er_rvalid_latency", e_rv_cyc - e_start_cyc, 3);
        chk("er_data", e_rv_data, 16'hBEEF);

        // simultaneous requests after reset
        apply_reset();
        grant_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_h(1'b0, 1'b1, 8'(8'h40 + i), 16'(16'hA000 + i));
            push_e(1'b1, 8'(8'h50 + i), 16'(16'hB000 + i));
        end
        wait_idle(100);
`ifdef CNN_ARB_HOST_PRIORITY_EN
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        chk("grant_count", grant_q.size(), 8);
        for (int i = 0; i < 4; i++) begin
            if (grant_q.size() > i) chk("grant_order", grant_q[i], exp_q[i]);
        end

        // read and write together is a write
        push_h(1'b1, 1'b1, 8'h20, 16'h00FF);
        wait_idle(50);
        chk("rw_is_write_addr", last_mwr_addr, 16'h0020);
        chk("rw_is_write_latency", h_done_cyc - h_start_cyc, 2);
        push_h(1'b1, 1'b0, 8'h20, 16'h0000);
        wait_idle(50);
        chk("rw_readback", h_done_data, 16'h00FF);

        // reset in the CAPTURE cycle of a host read
        push_h(1'b1, 1'b0, 8'h20, 16'h0000);
        run_cycle();
        run_cycle();
        run_cycle();
        @(negedge clk); #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_state", dbg_state, 2'd0);
        chk("midrst_mstrobes", {m_chipselect, m_read, m_write}, 3'b000);
        chk("midrst_waitrequest", h_waitrequest, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        rel_cyc = cyc;
        drive_inputs();
        wait_idle(50);
        chk("midrst_reissue_latency", h_done_cyc - rel_cyc, 3);
        chk("midrst_readdata", h_done_data, 16'h00FF);

        // randomized traffic from both sides
        h_rate = 40; e_rate = 50;
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 2);
            push_h(op != 1, op != 0, 8'($urandom_range(0, 15)), 16'($urandom));
            push_e(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
        end
        wait_idle(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cnn_mem_arbiter.md
# cnn_mem_arbiter

Two-port arbiter and sequencer for the single-ported 256x16 `cnn_mem` parameter/image RAM. It shares the RAM between the HPS Avalon-MM slave path (host) and the CNN compute engine. It serializes their accesses and drives the RAM's chipselect/read/write strobes. It also absorbs the RAM's one-cycle registered read latency, returning data to the winning requester.

## Interface
- `ADDR_W`, 8, requester address width; zero-extended to the 16-bit RAM address.
- `DATA_W`, 16, data width of all data paths.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `h_chipselect` in 1: host Avalon-MM select.
- `h_read` in 1: host read request.
- `h_write` in 1: host write request.
- `h_address` in ADDR_W: host word address.
- `h_writedata` in DATA_W: host write data.
- `h_readdata` out DATA_W: host read data, valid when `h_waitrequest`=0 on a read.
- `h_waitrequest` out 1: host stall.
- `e_req` in 1: engine request, level, held until `e_gnt`.
- `e_we` in 1: engine write (1) or read (0).
- `e_addr` in ADDR_W: engine word address.
- `e_wdata` in DATA_W: engine write data.
- `e_gnt` out 1: one-cycle pulse; engine command accepted.
- `e_rvalid` out 1: one-cycle pulse; `e_rdata` valid.
- `e_rdata` out DATA_W: engine read data.
- `m_chipselect`, `m_read`, `m_write` out 1: RAM strobes.
- `m_address` out 16: RAM address.
- `m_writedata` out DATA_W: RAM write data.
- `m_val_out` in DATA_W: RAM registered read data.

## Operation
- Host request `hreq` = `h_chipselect & (h_read | h_write)`. If both `h_read` and `h_write` are set, the request is treated as a write.
- FSM states: IDLE, ISSUE, CAPTURE, RESP. All outputs are registered except `h_waitrequest`.
- IDLE: if `hreq` or `e_req` is set, pick a winner. Latch its op, address and data into the command registers and go to ISSUE. With no request, stay in IDLE.
- Arbitration is round-robin on `last_winner`. A lone requester always wins. On a tie, the requester that did not win last is granted. Reset sets `last_winner`=engine, so the host wins the first tie.
- ISSUE: drive `m_chipselect`=1, plus `m_write` or `m_read` and the latched address/data. Pulse `e_gnt` if the engine won. A write goes to RESP; a read goes to CAPTURE.
- CAPTURE: register `m_val_out` into the winner's read-data register. Go to RESP.
- RESP: for a host winner, `h_waitrequest`=0 for this cycle. For an engine read, pulse `e_rvalid`. Go to IDLE.
- `h_waitrequest` = `hreq & ~(state==RESP & winner==host)`. It equals 1 while `reset` is high and `hreq` is set.
- `h_readdata` and `e_rdata` hold their last value until the next read of the same requester.
- `m_*` strobes are 0 in every state except ISSUE.
- Reset mid-operation: return to IDLE immediately (asynchronous). All registered outputs go to 0 and any in-flight command is dropped with no response. The host must re-present it.
- Reset values: `m_*`=0, `e_gnt`=0, `e_rvalid`=0, `e_rdata`=0, `h_readdata`=0, state IDLE.

## Timing
- Host write: presented in cycle 0, RAM written at the end of cycle 1, `h_waitrequest`=0 in cycle 2. Next arbitration happens in cycle 3.
- Host read: `m_read` in cycle 1, capture in cycle 2, `h_readdata` valid with `h_waitrequest`=0 in cycle 3.
- Engine: `e_gnt` in cycle 1. For a read, `e_rvalid` is in cycle 3. The engine may change `e_req`/command from cycle 2 on.
- Throughput is one write per 3 cycles and one read per 4 cycles. With both requesters always requesting, grants alternate strictly.
- Requesters must hold the command stable until `e_gnt` or `h_waitrequest`=0.

## Configuration
- `CNN_ARB_HOST_PRIORITY_EN` defined: fixed priority. The host wins every tie, and `last_winner` is ignored, so the engine may starve.
- Macro undefined (default): round-robin as above.

## Test plan
- Reset, then host writes 0x1234 to address 0x05 → `m_write`=1 with `m_address`=0x0005 in cycle 1, `h_waitrequest`=0 in cycle 2. A later host read of 0x05 returns `h_readdata`=0x1234 in cycle 3.
- Engine write 0xBEEF to 0x10, then engine read of 0x10 → `e_gnt` pulses in each ISSUE. The read gives `e_rvalid`=1 with `e_rdata`=0xBEEF 3 cycles after the request.
- Host and engine request in the same cycle after reset, repeated 4 times → grant order host, engine, host, engine. With `CNN_ARB_HOST_PRIORITY_EN` defined, the order is host ×4 and the engine waits.
- Host asserts `h_read` and `h_write` together with data 0x00FF at 0x20 → a write is performed and a read-back of 0x20 returns 0x00FF.
- Reset asserted during CAPTURE of a host read → state returns to IDLE asynchronously, all `m_*`=0, no `e_rvalid`. `h_waitrequest` stays 1 until the re-presented read completes.
